// File: rtl/int_expand.sv
// int_expand: rebuilds a linear sample from exponent k and a 1.F mantissa, round-half-up with saturation.
module int_expand #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 16,
  parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SHIFT_WIDTH-1:0] int_part,
  input  logic [NORM_WIDTH-1:0]  data_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   sat,
  output logic                   mant_err
);
  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, SEND} state_t;
  // aligned value can grow by the largest possible left shift, so nothing is lost before the saturation check
  localparam int AW = NORM_WIDTH + (1 << SHIFT_WIDTH);
  localparam logic [31:0] FW  = 32'(FRAC_WIDTH);
  localparam logic [31:0] DW1 = 32'(DATA_WIDTH - 1);
  state_t                 state_q;
  logic [SHIFT_WIDTH-1:0] k_q;
  logic [NORM_WIDTH-1:0]  m_q;
  logic [AW-1:0]          a_q, a_d, m_ext;
  logic                   r_q, r_d, right, sat_d;
  logic [31:0]            k32, shr, shl;
  logic [AW:0]            sum;
  logic [DATA_WIDTH-1:0]  data_d;
  assign in_ready = state_q == IDLE;
  always_comb begin
    k32    = 32'(k_q);
    right  = k32 <= FW;
    shr    = FW - k32;
    shl    = k32 - FW;
    m_ext  = AW'(m_q);
    a_d    = right ? m_ext >> shr : m_ext << shl;
    r_d    = right && shr != 32'd0 && |(m_ext & (AW'(1) << (shr - 32'd1)));
    sum    = {1'b0, a_q} + (AW+1)'(r_q);
    sat_d  = (sum >> DATA_WIDTH) != '0 || k32 > DW1;
    data_d = sat_d ? '1 : sum[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      m_q       <= '0;
      a_q       <= '0;
      r_q       <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat       <= 1'b0;
      mant_err  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          k_q     <= int_part;
          m_q     <= data_in;
          state_q <= ALIGN;
        end
        ALIGN: begin
          a_q     <= a_d;
          r_q     <= r_d;
          state_q <= ROUND;
        end
        ROUND: begin
          out_valid <= 1'b1;
          mant_err  <= !m_q[NORM_WIDTH-1];
          data_out  <= m_q[NORM_WIDTH-1] ? data_d : '0;
          sat       <= m_q[NORM_WIDTH-1] && sat_d;
          state_q   <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/int_expand.md
INT_EXPAND -- requirements
Module: int_expand

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the reconstructed linear sample.
REQ-002 Parameter FRAC_WIDTH, default 16, fraction bits of the normalized mantissa.
REQ-003 Parameter NORM_WIDTH, default FRAC_WIDTH+1, mantissa width including the hidden-one bit.
REQ-004 Parameter SHIFT_WIDTH, default $clog2(DATA_WIDTH), width of the exponent (int_part) input.
REQ-005 clk  input  1  single clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream has a valid {int_part, data_in} pair.
REQ-008 in_ready  output  1  block can accept a pair; combinational, high only in IDLE.
REQ-009 int_part  input  SHIFT_WIDTH  exponent k, the MSB index of the original sample.
REQ-010 data_in  input  NORM_WIDTH  unsigned mantissa M, format 1.FRAC_WIDTH, with bit NORM_WIDTH-1 the hidden one.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_valid  output  1  data_out, sat and mant_err are valid; registered.
REQ-013 data_out  output  DATA_WIDTH  reconstructed sample; registered.
REQ-014 sat  output  1  result was clamped to all-ones; registered, qualified by out_valid.
REQ-015 mant_err  output  1  data_in[NORM_WIDTH-1] was 0; registered, qualified by out_valid.

Function
REQ-016 The FSM SHALL have states IDLE, ALIGN, ROUND and SEND, and SHALL enter IDLE out of reset.
REQ-017 IDLE: on in_valid&&in_ready, the block SHALL capture int_part and data_in and go to ALIGN; otherwise it stays in IDLE.
REQ-018 ALIGN SHALL compute s = FRAC_WIDTH-k, register A = M>>s and round bit r = M[s-1] (r=0 when s=0), then go to ROUND.
REQ-019 When k>FRAC_WIDTH, the shift SHALL be a left shift by k-FRAC_WIDTH with r=0.
REQ-020 ROUND SHALL form R = A+r in DATA_WIDTH+1 bits, which is round-half-up.
  - If R >= 2^DATA_WIDTH, or k > DATA_WIDTH-1: data_out = all-ones and sat = 1.
  - Otherwise: data_out = R[DATA_WIDTH-1:0] and sat = 0.
  - ROUND SHALL then set out_valid = 1 and go to SEND.
REQ-021 When the captured M[NORM_WIDTH-1] is 0, ROUND SHALL output data_out = 0, sat = 0, mant_err = 1; otherwise mant_err = 0.
REQ-022 Latency: out_valid SHALL rise on the 3rd rising edge counting the accepting edge as the 1st.
REQ-023 SEND SHALL hold out_valid, data_out, sat and mant_err stable while out_ready = 0, for an unbounded stall.
REQ-024 SEND with out_ready = 1 SHALL clear out_valid and return to IDLE on that edge; data_out, sat and mant_err keep their values.
REQ-025 in_ready SHALL be 0 in ALIGN, ROUND and SEND; in_valid and data changes in those states SHALL be ignored.
REQ-026 Throughput SHALL be one sample per 4 cycles when out_ready is held high.
REQ-027 out_ready asserted before out_valid SHALL have no effect.
REQ-028 Intermediate widths SHALL be wide enough that no bits are lost before the saturation check.

Reset
REQ-029 reset SHALL force state = IDLE, out_valid = 0, data_out = 0, sat = 0, mant_err = 0, and clear the captured registers.
REQ-030 reset asserted mid-operation (ALIGN, ROUND or SEND) SHALL abort the sample with no out_valid pulse; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-031 reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 k=0, M=0x10000 -> data_out=1, sat=0, mant_err=0, out_valid on the 3rd edge.
REQ-033 Rounding cases:
  - k=4, M=0x18000 -> 24.
  - k=3, M=0x10800 (8.25) -> 8.
  - k=3, M=0x11000 (8.5) -> 9.
  - k=0, M=0x18000 -> 2.
REQ-034 k=15, M=0x1FFFF -> data_out=0xFFFF, sat=1.
REQ-035 k=5, M=0x0ABCD -> data_out=0, mant_err=1, sat=0.
REQ-036 Stall out_ready=0 for 10 cycles in SEND -> outputs stable, in_ready=0; then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
REQ-037 Reset pulsed in ROUND -> no out_valid; a following k=4, M=0x18000 -> 24 with nominal latency.
